// File: rtl/MD_pkg.sv
// Shared definitions for the neighbour-force register bank controller.
package MD_pkg;

  localparam int unsigned NUM_FILTERS = 7;

  // Five lifecycle states need a 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC   = 3'd1,
    DRAIN = 3'd2,
    PEND  = 3'd3,
    REL   = 3'd4
  } nb_reg_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i wins.
module rr_arbiter #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned PtrW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] req_i,
  input  logic             en_i,
  input  logic [PtrW-1:0]  ptr_i,
  output logic [WIDTH-1:0] gnt_o
);

  int              idx;
  logic            found;
  logic [PtrW-1:0] sel;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= int'(WIDTH)) idx = idx - int'(WIDTH);
      sel = PtrW'(idx);
      if (en_i && !found && req_i[sel]) begin
        gnt_o[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nb_reg_scheduler.sv
// Accumulate/release scheduler for the neighbour-force registers and their one-hot mux.
module nb_reg_scheduler
  import MD_pkg::*;
#(
  parameter int unsigned NUM_FILTERS = MD_pkg::NUM_FILTERS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_FILTERS-1:0] i_acc_req,
  input  logic [NUM_FILTERS-1:0] i_acc_last,
  output logic [NUM_FILTERS-1:0] o_acc_grant,
  output logic [NUM_FILTERS-1:0] o_reg_select,
  output logic [NUM_FILTERS-1:0] o_reg_release_select,
  input  logic                   i_release_ready,
  output logic [NUM_FILTERS-1:0] o_reg_clear,
  output logic [NUM_FILTERS-1:0] o_filter_stall,
  output logic                   o_busy
);

  localparam int unsigned PtrW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;

  nb_reg_state_t          state_q [NUM_FILTERS];
  nb_reg_state_t          state_d [NUM_FILTERS];
  logic [PtrW-1:0]        acc_ptr_q, acc_ptr_d;
  logic [PtrW-1:0]        rel_ptr_q, rel_ptr_d;
  logic [NUM_FILTERS-1:0] sel_q, rel_sel_q, rel_sel_d, clr_q, clr_d;
  logic [NUM_FILTERS-1:0] acc_elig, pend, rel_gnt;
  logic                   rel_en, fire, any_active;

  // Pointer to the index just past the set bit of a one-hot vector.
  function automatic logic [PtrW-1:0] ptr_after(input logic [NUM_FILTERS-1:0] oh);
    int n;
    n = 0;
    for (int i = 0; i < int'(NUM_FILTERS); i++) begin
      if (oh[i]) n = (i + 1 == int'(NUM_FILTERS)) ? 0 : i + 1;
    end
    return PtrW'(n);
  endfunction

  always_comb begin
    acc_elig       = '0;
    pend           = '0;
    o_filter_stall = '0;
    any_active     = 1'b0;
    for (int i = 0; i < int'(NUM_FILTERS); i++) begin
      acc_elig[i]       = i_acc_req[i] && (state_q[i] == IDLE || state_q[i] == ACC);
      pend[i]           = (state_q[i] == PEND);
      o_filter_stall[i] = (state_q[i] == DRAIN) || (state_q[i] == PEND) || (state_q[i] == REL);
      if (state_q[i] != IDLE) any_active = 1'b1;
    end
  end

  rr_arbiter #(
    .WIDTH (NUM_FILTERS)
  ) u_acc_arb (
    .req_i (acc_elig),
    .en_i  (rst_n),
    .ptr_i (acc_ptr_q),
    .gnt_o (o_acc_grant)
  );

  assign rel_en = rst_n && (rel_sel_q == '0);

  rr_arbiter #(
    .WIDTH (NUM_FILTERS)
  ) u_rel_arb (
    .req_i (pend),
    .en_i  (rel_en),
    .ptr_i (rel_ptr_q),
    .gnt_o (rel_gnt)
  );

  assign fire = (rel_sel_q != '0) && i_release_ready;

  always_comb begin
    for (int i = 0; i < int'(NUM_FILTERS); i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        IDLE, ACC: if (o_acc_grant[i]) state_d[i] = i_acc_last[i] ? DRAIN : ACC;
        DRAIN:     state_d[i] = PEND;
        PEND:      if (rel_gnt[i]) state_d[i] = REL;
        REL:       if (fire && rel_sel_q[i]) state_d[i] = IDLE;
        default:   state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    acc_ptr_d = acc_ptr_q;
    rel_ptr_d = rel_ptr_q;
    rel_sel_d = rel_sel_q;
    clr_d     = '0;
    if (o_acc_grant != '0) acc_ptr_d = ptr_after(o_acc_grant);
    if (fire) begin
      rel_sel_d = '0;
      clr_d     = rel_sel_q;
      rel_ptr_d = ptr_after(rel_sel_q);
    end else if (rel_gnt != '0) begin
      rel_sel_d = rel_gnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_FILTERS); i++) state_q[i] <= IDLE;
      acc_ptr_q <= '0;
      rel_ptr_q <= '0;
      sel_q     <= '0;
      rel_sel_q <= '0;
      clr_q     <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_FILTERS); i++) state_q[i] <= state_d[i];
      acc_ptr_q <= acc_ptr_d;
      rel_ptr_q <= rel_ptr_d;
      sel_q     <= o_acc_grant;
      rel_sel_q <= rel_sel_d;
      clr_q     <= clr_d;
    end
  end

  assign o_reg_select         = sel_q;
  assign o_reg_release_select = rel_sel_q;
  assign o_reg_clear          = clr_q;
  assign o_busy = any_active || (sel_q != '0) || (rel_sel_q != '0) || (clr_q != '0) ||
                  (o_acc_grant != '0);

endmodule

// File: tb/tb_nb_reg_scheduler.sv
// Self-checking bench for nb_reg_scheduler with a per-register lifecycle reference model.
module tb_nb_reg_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] acc_req, acc_last, grant, sel, rsel, clr, stall;
  logic         rdy, busy;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 accumulating, 2 draining, 3 pending, 4 releasing.
  int           ph [N];
  int           aptr, rptr;
  logic [N-1:0] e_sel, e_rel, e_clr;
  bit           armed;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] last;
    logic         rdy;
    logic [N-1:0] g;
    logic [N-1:0] s;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  nb_reg_scheduler #(
    .NUM_FILTERS (N)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_acc_req            (acc_req),
    .i_acc_last           (acc_last),
    .o_acc_grant          (grant),
    .o_reg_select         (sel),
    .o_reg_release_select (rsel),
    .i_release_ready      (rdy),
    .o_reg_clear          (clr),
    .o_filter_stall       (stall),
    .o_busy               (busy)
  );

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    if (!rst_n) return '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (aptr + k) % N;
      if (acc_req[idx] && ph[idx] <= 1) return N'(1 << idx);
    end
    return '0;
  endfunction

  task automatic check_all();
    logic [N-1:0] eg, es;
    logic         eb;
    eg = exp_grant();
    es = '0;
    eb = (e_sel != 0) || (e_rel != 0) || (e_clr != 0) || (eg != 0);
    for (int i = 0; i < N; i++) begin
      es[i] = (ph[i] >= 2);
      if (ph[i] != 0) eb = 1'b1;
    end
    chk("grant", grant, eg);
    chk("select", sel, e_sel);
    chk("release_select", rsel, e_rel);
    chk("clear", clr, e_clr);
    chk("stall", stall, es);
    chk("busy", N'(busy), N'(eb));
  endtask

  task automatic model_update();
    int           old [N];
    logic [N-1:0] g, nrel;
    bit           fire, done;
    g = exp_grant();
    if (!rst_n) begin
      for (int i = 0; i < N; i++) ph[i] = 0;
      aptr = 0; rptr = 0; e_sel = '0; e_rel = '0; e_clr = '0;
      return;
    end
    for (int i = 0; i < N; i++) old[i] = ph[i];
    fire = (e_rel != 0) && rdy;
    nrel = e_rel;
    for (int i = 0; i < N; i++) if (old[i] == 2) ph[i] = 3;
    if (fire) begin
      for (int i = 0; i < N; i++) if (e_rel[i]) begin ph[i] = 0; rptr = (i + 1) % N; end
      nrel = '0;
    end else if (e_rel == 0) begin
      done = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (rptr + k) % N;
        if (!done && old[idx] == 3) begin ph[idx] = 4; nrel = N'(1 << idx); done = 1; end
      end
    end
    for (int i = 0; i < N; i++) if (g[i]) begin ph[i] = acc_last[i] ? 2 : 1; aptr = (i + 1) % N; end
    e_clr = fire ? e_rel : '0;
    e_sel = g;
    e_rel = nrel;
  endtask

  task automatic drive(input logic rn, input logic [N-1:0] req, input logic [N-1:0] last,
                       input logic r);
    rst_n = rn; acc_req = req; acc_last = last; rdy = r;
    #1;
    if (armed) check_all();
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    armed = 0;
    for (int i = 0; i < N; i++) ph[i] = 0;
    aptr = 0; rptr = 0; e_sel = '0; e_rel = '0; e_clr = '0;
    tbl[0] = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0000};
    tbl[1] = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 4'b0001};
    tbl[2] = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 4'b0010};
    tbl[3] = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b0100};
    tbl[4] = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b1000};
    tbl[5] = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 4'b0001};

    // Reset held three cycles with all filters requesting.
    drive(1'b0, 4'b1111, 4'b0000, 1'b0); tick();
    armed = 1;
    drive(1'b0, 4'b1111, 4'b0000, 1'b0); tick();
    drive(1'b0, 4'b1111, 4'b0000, 1'b0);
    chk("reset_busy", N'(busy), '0);
    chk("reset_grant", grant, '0);
    tick();

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, tbl[i].req, tbl[i].last, tbl[i].rdy);
      chk("tbl_grant", grant, tbl[i].g);
      chk("tbl_select", sel, tbl[i].s);
      tick();
    end

    // Filter 2 last contribution, immediate release, then reuse.
    drive(1'b1, 4'b0100, 4'b0100, 1'b1); chk("t3_last_grant", grant, 4'b0100); tick();
    drive(1'b1, 4'b0000, 4'b0000, 1'b1); chk("t3_stall1", N'(stall[2]), 1); tick();
    drive(1'b1, 4'b0000, 4'b0000, 1'b1); chk("t3_stall2", N'(stall[2]), 1); tick();
    drive(1'b1, 4'b0000, 4'b0000, 1'b1);
    chk("t3_rel", rsel, 4'b0100); chk("t3_stall3", N'(stall[2]), 1); tick();
    drive(1'b1, 4'b0100, 4'b0000, 1'b1);
    chk("t3_clear", clr, 4'b0100); chk("t3_unstall", N'(stall[2]), 0);
    chk("t3_regrant", grant, 4'b0100); tick();
    drive(1'b1, 4'b0000, 4'b0000, 1'b1); chk("t3_sel_after_clear", sel, 4'b0100); tick();

    // Two registers pending, release held back by ready.
    drive(1'b0, 4'b0000, 4'b0000, 1'b0); tick();
    drive(1'b1, 4'b0001, 4'b0001, 1'b0); chk("t4_g0", grant, 4'b0001); tick();
    drive(1'b1, 4'b1000, 4'b1000, 1'b0); chk("t4_g3", grant, 4'b1000); tick();
    drive(1'b1, 4'b0000, 4'b0000, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b0000, 4'b0000, 1'b0); chk("t4_hold", rsel, 4'b0001); tick();
    end
    drive(1'b1, 4'b0000, 4'b0000, 1'b1); chk("t4_fire", rsel, 4'b0001); tick();
    drive(1'b1, 4'b0000, 4'b0000, 1'b1);
    chk("t4_gap", rsel, 4'b0000); chk("t4_clr0", clr, 4'b0001); tick();
    drive(1'b1, 4'b0000, 4'b0000, 1'b0); chk("t4_rel3", rsel, 4'b1000); tick();

    // Reset while a release is outstanding.
    drive(1'b0, 4'b0000, 4'b0000, 1'b0); tick();
    drive(1'b1, 4'b0010, 4'b0010, 1'b0); chk("t5_g1", grant, 4'b0010); tick();
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      drive(1'b1, 4'b0000, 4'b0000, 1'b0);
      if (rsel == 4'b0010) seen = 1;
      else tick();
    end
    chk("t5_rel_seen", N'(seen), 1);
    drive(1'b0, 4'b0000, 4'b0000, 1'b0); tick();
    drive(1'b0, 4'b0000, 4'b0000, 1'b0);
    chk("t5_rel", rsel, '0); chk("t5_clr", clr, '0);
    chk("t5_stall", stall, '0); chk("t5_busy", N'(busy), 0); tick();

    // Filter 1 parked in PEND behind filter 2's outstanding release.
    drive(1'b1, 4'b0100, 4'b0100, 1'b0); chk("t6_g2", grant, 4'b0100); tick();
    drive(1'b1, 4'b0010, 4'b0010, 1'b0); chk("t6_g1", grant, 4'b0010); tick();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 4'b0000, 4'b0000, 1'b0); tick(); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'b0011, 4'b0000, 1'b0);
      chk("t6_grant0", grant, 4'b0001); chk("t6_stall1", N'(stall[1]), 1); tick();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) != 0), N'($urandom), N'($urandom & $urandom),
            ($urandom_range(0, 2) != 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
